// File: rtl/mig_app_arbiter_if.sv
// Bus interfaces for the MIG app-port arbiter.
//   mig_req_if : one requester's command/write-data path plus its read-return strobe.
//                master = requester, slave = arbiter.
//   mig_app_if : MIG native app interface (command, write data, read return).
//                master = arbiter, slave = MIG.
interface mig_req_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 256
);
  logic                  valid;
  logic                  ready;
  logic                  is_read;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  rsp_valid;

  modport master (output valid, is_read, addr, wdata, wmask, input ready, rsp_valid);
  modport slave  (input valid, is_read, addr, wdata, wmask, output ready, rsp_valid);
endinterface

interface mig_app_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 256
);
  logic                  rdy;
  logic                  en;
  logic [2:0]            cmd;
  logic [ADDR_W-1:0]     addr;
  logic                  wdf_rdy;
  logic                  wdf_wren;
  logic                  wdf_end;
  logic [DATA_W-1:0]     wdf_data;
  logic [DATA_W/8-1:0]   wdf_mask;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_data_valid;

  modport master (output en, cmd, addr, wdf_wren, wdf_end, wdf_data, wdf_mask,
                  input rdy, wdf_rdy, rd_data, rd_data_valid);
  modport slave  (input en, cmd, addr, wdf_wren, wdf_end, wdf_data, wdf_mask,
                  output rdy, wdf_rdy, rd_data, rd_data_valid);
endinterface

// File: rtl/mig_app_arbiter.sv
// Round-robin arbiter sharing one MIG native app interface between two
// requesters (0 = host pipe-command path, 1 = auxiliary engine). One command
// is in flight at a time; app_en / app_wdf_wren are held until the MIG
// accepts each. Read returns are steered to their originator through an
// in-order tag FIFO.
// Ports:
//   sys_clk, rst_n     clock, asynchronous active-low reset
//   calib_done         MIG calibration complete; gates new grants
//   req0, req1         requester buses (valid/ready/is_read/addr/wdata/wmask, rsp_valid)
//   app                MIG app interface
//   rsp_data           read data shared by both requesters
//   rd_orphan_err      sticky: read data arrived with no outstanding read
module mig_app_arbiter #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 256,
  parameter int TAG_DEPTH = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              calib_done,
  mig_req_if.slave          req0,
  mig_req_if.slave          req1,
  mig_app_if.master         app,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rd_orphan_err
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int MSK_W = DATA_W / 8;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TAG_DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_q, state_d;
  logic               run_q;          // low during and one cycle after reset: keeps ready at 0
  logic               last_grant_q;
  logic               gnt_id_q;
  logic               is_read_q;
  logic               app_en_q;
  logic               wren_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [MSK_W-1:0]   wmask_q;

  // Tag FIFO
  logic               tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               fifo_full, fifo_empty;

  logic               rsp0_q, rsp1_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               orphan_q;

  logic               elig0, elig1;
  logic               grant_valid, grant_id;
  logic               cmd_done, wdf_done, issue_done;
  logic               push, pop;

  logic               sel_is_read;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [MSK_W-1:0]   sel_wmask;

  assign fifo_full  = (count_q == CNT_MAX);
  assign fifo_empty = (count_q == '0);

  assign elig0 = req0.valid && calib_done && (!req0.is_read || !fifo_full);
  assign elig1 = req1.valid && calib_done && (!req1.is_read || !fifo_full);

  assign cmd_done   = app_en_q && app.rdy;
  assign wdf_done   = wren_q && app.wdf_rdy;
  // Both strobes will be low after this edge: each is either already low or accepted now.
  assign issue_done = (!app_en_q || app.rdy) && (!wren_q || app.wdf_rdy);

  assign push = (state_q == ISSUE) && cmd_done && is_read_q;
  assign pop  = app.rd_data_valid && !fifo_empty;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    state_d     = state_q;
    if (state_q == IDLE && run_q) begin
      if (elig0 && elig1) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (elig0 || elig1) begin
        grant_valid = 1'b1;
        grant_id    = elig1;
      end
    end
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   if (issue_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_is_read = grant_id ? req1.is_read : req0.is_read;
  assign sel_addr    = grant_id ? req1.addr    : req0.addr;
  assign sel_wdata   = grant_id ? req1.wdata   : req0.wdata;
  assign sel_wmask   = grant_id ? req1.wmask   : req0.wmask;

  assign req0.ready = grant_valid && !grant_id;
  assign req1.ready = grant_valid &&  grant_id;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Command/write-data issue registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      is_read_q    <= 1'b0;
      app_en_q     <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else if (state_q == IDLE) begin
      if (grant_valid) begin
        last_grant_q <= grant_id;
        gnt_id_q     <= grant_id;
        is_read_q    <= sel_is_read;
        app_en_q     <= 1'b1;
        wren_q       <= !sel_is_read;
        addr_q       <= sel_addr;
        wdata_q      <= sel_is_read ? '0 : sel_wdata;
        wmask_q      <= sel_is_read ? '0 : sel_wmask;
      end
    end else begin
      if (cmd_done) app_en_q <= 1'b0;
      if (wdf_done) wren_q   <= 1'b0;
      if (issue_done) begin
        is_read_q <= 1'b0;
        addr_q    <= '0;
        wdata_q   <= '0;
        wmask_q   <= '0;
      end
    end
  end

  assign app.en       = app_en_q;
  assign app.cmd      = {2'b00, is_read_q};
  assign app.addr     = addr_q;
  assign app.wdf_wren = wren_q;
  assign app.wdf_end  = wren_q;
  assign app.wdf_data = wdata_q;
  assign app.wdf_mask = wmask_q;

  // NOTE: the tag storage is not reset; count and pointers alone decide which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge sys_clk) begin
    if (push) tag_mem[wr_ptr_q] <= gnt_id_q;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Read-return steering: one-cycle pulse to the requester whose tag is at the head.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rsp_data_q <= '0;
      orphan_q   <= 1'b0;
    end else begin
      rsp0_q <= pop && !tag_mem[rd_ptr_q];
      rsp1_q <= pop &&  tag_mem[rd_ptr_q];
      if (pop) rsp_data_q <= app.rd_data;
      if (app.rd_data_valid && fifo_empty) orphan_q <= 1'b1;
    end
  end

  assign req0.rsp_valid = rsp0_q;
  assign req1.rsp_valid = rsp1_q;
  assign rsp_data       = rsp_data_q;
  assign rd_orphan_err  = orphan_q;

endmodule
